// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the writeback stage.
//   XLEN               - datapath width
//   DEFAULT_INSTRET_W  - default width of the retired-instruction counter
//   load_op_e          - funct3 encodings of the load instructions
//   wb_state_e         - writeback controller states
package riscv_pkg;

  localparam int XLEN              = 32;
  localparam int DEFAULT_INSTRET_W = 64;

  typedef enum logic [2:0] {
    LOAD_LB  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LW  = 3'b010,
    LOAD_LBU = 3'b100,
    LOAD_LHU = 3'b101
  } load_op_e;

  typedef enum logic [0:0] {
    WB_IDLE    = 1'b0,
    WB_WAIT_LD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_extract.sv
// load_extract: combinational load-data alignment and extension.
// Ports:
//   word    in  XLEN  aligned 32-bit memory word
//   offset  in  2     byte offset within the word (address bits [1:0])
//   load_op in  3     funct3 of the load
//   result  out XLEN  value to write back
module load_extract
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      load_op,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase

    // Halfword alignment is enforced upstream, so offset[0] plays no part.
    half_sel = offset[1] ? word[31:16] : word[15:0];

    result = word;
    case (load_op)
      LOAD_LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LOAD_LH:  result = {{(XLEN-16){half_sel[15]}}, half_sel};
      LOAD_LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
      LOAD_LHU: result = {{(XLEN-16){1'b0}}, half_sel};
      // LW and the undefined encodings pass the word through unchanged.
      default:  result = word;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage. Accepts retiring instructions from
// MEM, waits for variable-latency load responses, aligns/extends load data
// and drives the register file write port. Counts retired instructions.
// Ports:
//   clk, reset                   clock, async active-high reset
//   in_valid/in_ready            MEM handshake (transfer when both high)
//   in_rd, in_reg_write          destination register and write enable
//   in_result                    ALU/CSR result, or effective address for loads
//   in_is_load, in_load_op       load flag and funct3
//   ld_rsp_valid/data/err        load response (one-cycle pulse)
//   wb_rd, wb_data, wb_en        register file write port (registered)
//   busy                         a load is outstanding
//   load_fault                   one-cycle pulse on load bus error
//   instret                      retired-instruction counter (wraps)
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int INSTRET_W = DEFAULT_INSTRET_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rd,
  input  logic                 in_reg_write,
  input  logic [XLEN-1:0]      in_result,
  input  logic                 in_is_load,
  input  logic [2:0]           in_load_op,
  input  logic                 ld_rsp_valid,
  input  logic [XLEN-1:0]      ld_rsp_data,
  input  logic                 ld_rsp_err,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 wb_en,
  output logic                 busy,
  output logic                 load_fault,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  wb_state_e             state_q, state_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic                  wb_en_q, wb_en_d;
  logic                  load_fault_q, load_fault_d;
  logic [INSTRET_W-1:0]  instret_q, instret_d;

  // Context of the outstanding load, captured at accept time.
  logic [4:0]            ld_rd_q, ld_rd_d;
  logic                  ld_reg_write_q, ld_reg_write_d;
  logic [2:0]            ld_op_q, ld_op_d;
  logic [1:0]            ld_off_q, ld_off_d;

  logic [XLEN-1:0]       ld_value;

  load_extract u_load_extract (
    .word    (ld_rsp_data),
    .offset  (ld_off_q),
    .load_op (ld_op_q),
    .result  (ld_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= WB_IDLE;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      wb_en_q        <= 1'b0;
      load_fault_q   <= 1'b0;
      instret_q      <= '0;
      ld_rd_q        <= '0;
      ld_reg_write_q <= 1'b0;
      ld_op_q        <= '0;
      ld_off_q       <= '0;
    end else begin
      state_q        <= state_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      wb_en_q        <= wb_en_d;
      load_fault_q   <= load_fault_d;
      instret_q      <= instret_d;
      ld_rd_q        <= ld_rd_d;
      ld_reg_write_q <= ld_reg_write_d;
      ld_op_q        <= ld_op_d;
      ld_off_q       <= ld_off_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    wb_en_d        = 1'b0;   // write enable and fault are single-cycle pulses
    load_fault_d   = 1'b0;
    instret_d      = instret_q;
    ld_rd_d        = ld_rd_q;
    ld_reg_write_d = ld_reg_write_q;
    ld_op_d        = ld_op_q;
    ld_off_d       = ld_off_q;

    case (state_q)
      WB_IDLE: begin
        // Load responses arriving here are stale and deliberately dropped.
        if (in_valid) begin
          if (in_is_load) begin
            ld_rd_d        = in_rd;
            ld_reg_write_d = in_reg_write;
            ld_op_d        = in_load_op;
            ld_off_d       = in_result[1:0];
            state_d        = WB_WAIT_LD;
          end else begin
            wb_rd_d   = in_rd;
            wb_data_d = in_result;
            wb_en_d   = in_reg_write && (in_rd != 5'd0);
            instret_d = instret_q + INSTRET_ONE;
          end
        end
      end
      WB_WAIT_LD: begin
        if (ld_rsp_valid) begin
          state_d = WB_IDLE;
          if (ld_rsp_err) begin
            // Faulting load does not retire and writes nothing.
            load_fault_d = 1'b1;
          end else begin
            wb_rd_d   = ld_rd_q;
            wb_data_d = ld_value;
            wb_en_d   = ld_reg_write_q && (ld_rd_q != 5'd0);
            instret_d = instret_q + INSTRET_ONE;
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  assign in_ready   = (state_q == WB_IDLE);
  assign busy       = (state_q == WB_WAIT_LD);
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_en      = wb_en_q;
  assign load_fault = load_fault_q;
  assign instret    = instret_q;

endmodule
